// File: rtl/t2mi_frame_scheduler.sv
// T2-MI packet sequencer: orders timestamp, L1-current and BB-frame packets per T2 frame
// and tracks the frame, superframe and block indices carried in the packet headers.
module t2mi_frame_scheduler #(
    parameter int SF_IDX_W          = 4,
    parameter bit TS_ENABLE_DEFAULT = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [7:0]          num_t2_frames,
    input  logic [9:0]          plp_num_blocks,
    input  logic [1:0]          timestamp_type,
    input  logic                CMD_READY,
    input  logic                PKT_DONE,
    output logic                CMD_VALID,
    output logic [1:0]          CMD_TYPE,
    output logic [7:0]          FRAME_IDX,
    output logic [SF_IDX_W-1:0] SUPERFRAME_IDX,
    output logic [9:0]          BLOCK_IDX,
    output logic                FIRST_OF_FRAME,
    output logic                ERR_CFG
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT_DONE} state_t;

    localparam logic [1:0] TYPE_BB = 2'd0;
    localparam logic [1:0] TYPE_L1 = 2'd1;
    localparam logic [1:0] TYPE_TS = 2'd2;

    state_t     state;
    logic [7:0] shadow_frames;
    logic [9:0] shadow_blocks;
    logic [1:0] shadow_ts_type;
    logic       last_block;
    logic       last_frame;

    // Reserved type 3 is handled like null: no timestamp packet.
    function automatic logic ts_enabled(input logic [1:0] tt);
        return TS_ENABLE_DEFAULT && (tt == 2'd1 || tt == 2'd2);
    endfunction

    function automatic logic [1:0] frame_opener(input logic [1:0] tt);
        return ts_enabled(tt) ? TYPE_TS : TYPE_L1;
    endfunction

    assign last_block = (BLOCK_IDX == shadow_blocks - 10'd1);
    assign last_frame = (FRAME_IDX == shadow_frames - 8'd1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= IDLE;
            shadow_frames  <= '0;
            shadow_blocks  <= '0;
            shadow_ts_type <= '0;
            CMD_VALID      <= 1'b0;
            CMD_TYPE       <= TYPE_BB;
            FRAME_IDX      <= '0;
            SUPERFRAME_IDX <= '0;
            BLOCK_IDX      <= '0;
            FIRST_OF_FRAME <= 1'b0;
            ERR_CFG        <= 1'b0;
        end else if (!START) begin
            // Loss of sync drops any pending command; the superframe index survives resync.
            state          <= IDLE;
            CMD_VALID      <= 1'b0;
            CMD_TYPE       <= TYPE_BB;
            FRAME_IDX      <= '0;
            BLOCK_IDX      <= '0;
            FIRST_OF_FRAME <= 1'b0;
            ERR_CFG        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shadow_frames  <= num_t2_frames;
                    shadow_blocks  <= plp_num_blocks;
                    shadow_ts_type <= timestamp_type;
                    if (num_t2_frames == 8'd0 || plp_num_blocks == 10'd0) begin
                        ERR_CFG <= 1'b1;
                    end else begin
                        ERR_CFG        <= 1'b0;
                        FRAME_IDX      <= '0;
                        BLOCK_IDX      <= '0;
                        CMD_TYPE       <= frame_opener(timestamp_type);
                        FIRST_OF_FRAME <= 1'b1;
                        CMD_VALID      <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (CMD_READY) begin
                        CMD_VALID      <= 1'b0;
                        FIRST_OF_FRAME <= 1'b0;
                        state          <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (PKT_DONE) begin
                        case (CMD_TYPE)
                            TYPE_TS: begin
                                CMD_TYPE  <= TYPE_L1;
                                CMD_VALID <= 1'b1;
                                state     <= ISSUE;
                            end
                            TYPE_L1: begin
                                CMD_TYPE  <= TYPE_BB;
                                BLOCK_IDX <= '0;
                                CMD_VALID <= 1'b1;
                                state     <= ISSUE;
                            end
                            default: begin
                                if (!last_block) begin
                                    BLOCK_IDX <= BLOCK_IDX + 10'd1;
                                    CMD_VALID <= 1'b1;
                                    state     <= ISSUE;
                                end else if (last_frame) begin
                                    // Superframe boundary: reload config before the next command.
                                    BLOCK_IDX      <= '0;
                                    FRAME_IDX      <= '0;
                                    SUPERFRAME_IDX <= SUPERFRAME_IDX + SF_IDX_W'(1);
                                    state          <= LOAD;
                                end else begin
                                    BLOCK_IDX      <= '0;
                                    FRAME_IDX      <= FRAME_IDX + 8'd1;
                                    CMD_TYPE       <= frame_opener(shadow_ts_type);
                                    FIRST_OF_FRAME <= 1'b1;
                                    CMD_VALID      <= 1'b1;
                                    state          <= ISSUE;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Bench for t2mi_frame_scheduler: table-driven configs, hand-written corner sequences and
// randomized traffic against a superframe-level command list model.
module tb_t2mi_frame_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic [7:0] num_t2_frames = 8'd0;
    logic [9:0] plp_num_blocks = 10'd0;
    logic [1:0] timestamp_type = 2'd0;
    logic       CMD_READY = 1'b0;
    logic       PKT_DONE = 1'b0;
    logic       CMD_VALID;
    logic [1:0] CMD_TYPE;
    logic [7:0] FRAME_IDX;
    logic [3:0] SUPERFRAME_IDX;
    logic [9:0] BLOCK_IDX;
    logic       FIRST_OF_FRAME;
    logic       ERR_CFG;

    t2mi_frame_scheduler #(.SF_IDX_W(4), .TS_ENABLE_DEFAULT(1'b1)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .num_t2_frames(num_t2_frames), .plp_num_blocks(plp_num_blocks),
        .timestamp_type(timestamp_type), .CMD_READY(CMD_READY), .PKT_DONE(PKT_DONE),
        .CMD_VALID(CMD_VALID), .CMD_TYPE(CMD_TYPE), .FRAME_IDX(FRAME_IDX),
        .SUPERFRAME_IDX(SUPERFRAME_IDX), .BLOCK_IDX(BLOCK_IDX),
        .FIRST_OF_FRAME(FIRST_OF_FRAME), .ERR_CFG(ERR_CFG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] t;
        logic [7:0] f;
        logic [9:0] b;
        logic       first;
        logic [3:0] sf;
    } cmd_t;

    typedef struct {
        int f;
        int n;
        int tt;
        int cnt;
        int first_t;
    } row_t;

    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t exp_q[$];
    int   m_sf = 0;
    int   sf_pos = 0;
    int   last_len = 0;
    int   last_first_t = 0;
    logic [7:0] nF = 8'd0;
    logic [9:0] nN = 10'd0;
    logic [1:0] nT = 2'd0;
    row_t tbl[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Expected command list for one whole superframe, built from the current config inputs.
    function automatic void refill();
        int   fr;
        int   nb;
        bit   ts;
        cmd_t c;
        fr = int'(num_t2_frames);
        nb = int'(plp_num_blocks);
        ts = (timestamp_type == 2'd1) || (timestamp_type == 2'd2);
        last_len = 0;
        for (int f = 0; f < fr; f++) begin
            if (ts) begin
                c.t = 2'd2; c.f = 8'(f); c.b = 10'd0; c.first = 1'b1; c.sf = 4'(m_sf);
                exp_q.push_back(c);
                last_len++;
            end
            c.t = 2'd1; c.f = 8'(f); c.b = 10'd0; c.first = !ts; c.sf = 4'(m_sf);
            exp_q.push_back(c);
            last_len++;
            for (int b = 0; b < nb; b++) begin
                c.t = 2'd0; c.f = 8'(f); c.b = 10'(b); c.first = 1'b0; c.sf = 4'(m_sf);
                exp_q.push_back(c);
                last_len++;
            end
        end
        m_sf = (m_sf + 1) % 16;
    endfunction

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (CMD_VALID) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        check("valid_timeout", 32'(CMD_VALID), 32'd1);
    endtask

    task automatic set_cfg(input int f, input int n, input int tt);
        num_t2_frames = 8'(f); plp_num_blocks = 10'(n); timestamp_type = 2'(tt);
        nF = 8'(f); nN = 10'(n); nT = 2'(tt);
    endtask

    // Serve one command as the packet builder would, optionally stalling CMD_READY.
    task automatic do_cmd(input int stall, input int done_dly, input bit pulse_in_issue);
        bit   ok;
        cmd_t e;
        logic [31:0] held;
        if (exp_q.size() == 0) begin
            refill();
            sf_pos = 0;
        end
        wait_valid(ok);
        if (!ok) return;
        e = exp_q.pop_front();
        held = 32'({CMD_TYPE, FRAME_IDX, BLOCK_IDX, FIRST_OF_FRAME, SUPERFRAME_IDX, ERR_CFG});
        check("cmd_fields", held, 32'({e.t, e.f, e.b, e.first, e.sf, 1'b0}));
        if (sf_pos == 0) last_first_t = int'(CMD_TYPE);
        for (int i = 0; i < stall; i++) begin
            if (pulse_in_issue && i == 5) PKT_DONE = 1'b1;
            step();
            PKT_DONE = 1'b0;
            check("stall_valid", 32'(CMD_VALID), 32'd1);
            check("stall_stable",
                  32'({CMD_TYPE, FRAME_IDX, BLOCK_IDX, FIRST_OF_FRAME, SUPERFRAME_IDX, ERR_CFG}), held);
        end
        CMD_READY = 1'b1;
        step();
        CMD_READY = 1'b0;
        check("valid_drop", 32'(CMD_VALID), 32'd0);
        if (sf_pos == 0) begin
            num_t2_frames = nF; plp_num_blocks = nN; timestamp_type = nT;
        end
        sf_pos++;
        repeat (done_dly) step();
        PKT_DONE = 1'b1;
        step();
        PKT_DONE = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0; START = 1'b0; CMD_READY = 1'b0; PKT_DONE = 1'b0;
        repeat (3) step();
        check("reset_outs",
              32'({CMD_VALID, CMD_TYPE, FRAME_IDX, SUPERFRAME_IDX, BLOCK_IDX, FIRST_OF_FRAME, ERR_CFG}), 32'd0);
        RST = 1'b1;
        step();
        exp_q.delete();
        m_sf = 0;
    endtask

    task automatic restart();
        START = 1'b0;
        step();
        exp_q.delete();
        START = 1'b1;
    endtask

    initial begin
        bit ok;
        tbl[0] = '{f: 2, n: 3, tt: 1, cnt: 10, first_t: 2};
        tbl[1] = '{f: 1, n: 1, tt: 0, cnt: 2,  first_t: 1};
        tbl[2] = '{f: 1, n: 1, tt: 3, cnt: 2,  first_t: 1};
        tbl[3] = '{f: 3, n: 2, tt: 2, cnt: 12, first_t: 2};
        tbl[4] = '{f: 2, n: 4, tt: 0, cnt: 10, first_t: 1};

        // Basic 2-frame superframe with timestamps.
        do_reset();
        set_cfg(2, 3, 1);
        START = 1'b1;
        for (int k = 0; k < 10; k++) do_cmd(0, 1, 1'b0);
        check("sf_after_10", 32'(SUPERFRAME_IDX), 32'd1);
        check("frame_after_10", 32'(FRAME_IDX), 32'd0);

        // Table of configurations, one complete superframe each.
        foreach (tbl[r]) begin
            restart();
            set_cfg(tbl[r].f, tbl[r].n, tbl[r].tt);
            for (int k = 0; k < tbl[r].cnt; k++) do_cmd(0, 0, 1'b0);
            check("tbl_len", 32'(last_len), 32'(tbl[r].cnt));
            check("tbl_first_type", 32'(last_first_t), 32'(tbl[r].first_t));
        end

        // Superframe index wraps after 16 single-frame superframes.
        do_reset();
        set_cfg(1, 1, 0);
        START = 1'b1;
        for (int k = 0; k < 32; k++) do_cmd(0, 1, 1'b0);
        check("sf_wrap", 32'(SUPERFRAME_IDX), 32'd0);

        // Long CMD_READY stall with a stray PKT_DONE in ISSUE.
        do_cmd(20, 1, 1'b1);
        do_cmd(0, 0, 1'b0);

        // Illegal config holds LOAD with ERR_CFG until corrected.
        restart();
        set_cfg(2, 0, 0);
        step();
        step();
        check("err_set", 32'(ERR_CFG), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("err_no_valid", 32'(CMD_VALID), 32'd0);
        end
        set_cfg(2, 2, 0);
        step();
        check("err_clear", 32'(ERR_CFG), 32'd0);
        check("err_first_cmd", 32'(CMD_VALID), 32'd1);
        for (int k = 0; k < 6; k++) do_cmd(0, 1, 1'b0);

        // Config change mid-superframe is deferred to the next superframe.
        restart();
        set_cfg(2, 3, 2);
        nN = 10'd5;
        for (int k = 0; k < 10; k++) do_cmd(0, 1, 1'b0);
        for (int k = 0; k < 14; k++) do_cmd(0, 0, 1'b0);
        check("deferred_len", 32'(last_len), 32'd14);

        // START drop in WAIT_DONE of frame 1, superframe 3, then resync and async reset.
        do_reset();
        set_cfg(2, 1, 1);
        START = 1'b1;
        for (int k = 0; k < 21; k++) do_cmd(0, 0, 1'b0);
        wait_valid(ok);
        check("drop_pre", 32'({CMD_TYPE, FRAME_IDX, SUPERFRAME_IDX}), 32'({2'd2, 8'd1, 4'd3}));
        CMD_READY = 1'b1;
        step();
        CMD_READY = 1'b0;
        step();
        START = 1'b0;
        step();
        check("drop_outs", 32'({CMD_VALID, FRAME_IDX, BLOCK_IDX, SUPERFRAME_IDX}),
              32'({1'b0, 8'd0, 10'd0, 4'd3}));
        START = 1'b1;
        exp_q.delete();
        m_sf = (m_sf + 15) % 16;
        step();
        check("resync_load", 32'(CMD_VALID), 32'd0);
        step();
        check("resync_cmd", 32'({CMD_VALID, CMD_TYPE, FRAME_IDX, FIRST_OF_FRAME, SUPERFRAME_IDX}),
              32'({1'b1, 2'd2, 8'd0, 1'b1, 4'd3}));
        #2 RST = 1'b0;
        #1;
        check("async_reset",
              32'({CMD_VALID, CMD_TYPE, FRAME_IDX, SUPERFRAME_IDX, BLOCK_IDX, FIRST_OF_FRAME, ERR_CFG}), 32'd0);
        step();

        // Randomized configs, stalls and PKT_DONE latencies.
        do_reset();
        set_cfg(int'($urandom_range(3, 1)), int'($urandom_range(4, 1)), int'($urandom_range(3, 0)));
        START = 1'b1;
        for (int k = 0; k < 150; k++) begin
            if (exp_q.size() == 0) begin
                nF = 8'($urandom_range(3, 1));
                nN = 10'($urandom_range(4, 1));
                nT = 2'($urandom_range(3, 0));
            end
            do_cmd(int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
